// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the button conditioner:
//   - btn_state_e : FSM state encoding (IDLE=0, PRESSED=1, HELD=2)
//   - *_DEF       : default parameter values for button_conditioner
//   - *_MAX       : largest legal parameter values; counter widths derive
//                   from these so any legal setting fits without overflow
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_e;

    localparam int unsigned DEBOUNCE_MS_DEF = 20;
    localparam int unsigned LONG_MS_DEF     = 1000;
    localparam int unsigned REPEAT_MS_DEF   = 200;
    localparam bit          ACTIVE_LOW_DEF  = 1'b1;

    localparam int unsigned DEBOUNCE_MS_MAX = 255;
    localparam int unsigned LONG_MS_MAX     = 65535;
    localparam int unsigned REPEAT_MS_MAX   = 65535;

    localparam int unsigned DB_CNT_W   = $clog2(DEBOUNCE_MS_MAX + 1);
    localparam int unsigned HOLD_CNT_W = $clog2(LONG_MS_MAX + 1);
    localparam int unsigned REP_CNT_W  = $clog2(REPEAT_MS_MAX + 1);

endpackage

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync
// Two-flop synchronizer bringing the asynchronous button pin into the
// i_clk domain.
//   i_clk   : destination clock
//   i_rst   : synchronous active-high reset, loads RESET_VAL into both flops
//   i_async : asynchronous input
//   o_sync  : synchronized output (two i_clk cycles of latency)
// RESET_VAL is the pin level of a released button, so reset never looks
// like a press to the logic downstream.
// -----------------------------------------------------------------------------
module btn_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would collapse the two stages into one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Synchronizes, debounces and interprets a mechanical push button.
//   MASTER_CLK : sole clock; all state changes on its rising edge
//   RST        : synchronous active-high reset (everything to "released")
//   tick_ms    : one-cycle enable, once per ms
//   btn_raw    : asynchronous raw button pin
//   btn_level  : debounced level, 1 = pressed
//   press      : one-cycle pulse in the cycle btn_level rises
//   release_p  : one-cycle pulse in the cycle btn_level falls
//                ("release" is a reserved word, hence the _p suffix)
//   long_press : one-cycle pulse when the hold reaches LONG_MS ticks
//   repeat_p   : one-cycle auto-repeat pulse every REPEAT_MS ticks in HELD
// Optional feature: define BUTTON_AUTO_REPEAT_EN to enable auto-repeat;
// without it repeat_p is tied low and HELD lasts until release.
// -----------------------------------------------------------------------------
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter int unsigned LONG_MS     = LONG_MS_DEF,
    parameter int unsigned REPEAT_MS   = REPEAT_MS_DEF,
    parameter bit          ACTIVE_LOW  = ACTIVE_LOW_DEF
) (
    input  logic MASTER_CLK,
    input  logic RST,
    input  logic tick_ms,
    input  logic btn_raw,
    output logic btn_level,
    output logic press,
    output logic release_p,
    output logic long_press,
    output logic repeat_p
);

    // Terminal counts: the event fires on the tick that would take the
    // counter to the full period, so the output lands one cycle after it.
    localparam logic [DB_CNT_W-1:0]   DB_LAST   = DB_CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(LONG_MS - 1);
    localparam logic [REP_CNT_W-1:0]  REP_LAST  = REP_CNT_W'(REPEAT_MS - 1);

    // ---------------------------------------------------------------- sync
    logic w_sync_raw;
    logic w_sync_level;

    btn_sync #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .i_clk   (MASTER_CLK),
        .i_rst   (RST),
        .i_async (btn_raw),
        .o_sync  (w_sync_raw)
    );

    assign w_sync_level = ACTIVE_LOW ? ~w_sync_raw : w_sync_raw;

    // ------------------------------------------------------------ debounce
    logic [DB_CNT_W-1:0] r_db_cnt;
    logic                r_level;
    logic                w_db_done;
    logic                w_rise;
    logic                w_fall;

    // Level change accepted on this edge.
    assign w_db_done = (w_sync_level != r_level) && tick_ms && (r_db_cnt == DB_LAST);
    assign w_rise    = w_db_done && !r_level;
    assign w_fall    = w_db_done &&  r_level;

    always_ff @(posedge MASTER_CLK) begin
        if (RST) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else if (w_sync_level == r_level) begin
            // Agreement (including the end of a glitch) restarts the count.
            r_db_cnt <= '0;
        end else if (tick_ms) begin
            if (r_db_cnt == DB_LAST) begin
                r_level  <= ~r_level;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_CNT_W'(1);
            end
        end
    end

    // ----------------------------------------------------------------- FSM
    btn_state_e            r_state, w_state_nxt;
    logic [HOLD_CNT_W-1:0] r_hold_cnt, w_hold_nxt;
    logic                  r_press, w_press_nxt;
    logic                  r_release, w_release_nxt;
    logic                  r_long, w_long_nxt;
    logic                  r_repeat, w_repeat_nxt;
`ifdef BUTTON_AUTO_REPEAT_EN
    logic [REP_CNT_W-1:0]  r_rep_cnt, w_rep_nxt;
`else
    logic                  w_unused_rep_cfg;
    assign w_unused_rep_cfg = ^REP_LAST;
`endif

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
        w_rep_nxt     = r_rep_cnt;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = PRESSED;
                    w_press_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            PRESSED: begin
                // Release is tested first so it wins over a coinciding long_press.
                if (w_fall) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                end else if (tick_ms) begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_nxt = HELD;
                        w_long_nxt  = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                        w_rep_nxt   = '0;
`endif
                    end else begin
                        w_hold_nxt = r_hold_cnt + HOLD_CNT_W'(1);
                    end
                end
            end
            HELD: begin
                if (w_fall) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                end else if (tick_ms) begin
                    if (r_rep_cnt == REP_LAST) begin
                        w_repeat_nxt = 1'b1;
                        w_rep_nxt    = '0;
                    end else begin
                        w_rep_nxt = r_rep_cnt + REP_CNT_W'(1);
                    end
`endif
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge MASTER_CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            r_rep_cnt  <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
            r_repeat   <= w_repeat_nxt;
`ifdef BUTTON_AUTO_REPEAT_EN
            r_rep_cnt  <= w_rep_nxt;
`endif
        end
    end

    assign btn_level  = r_level;
    assign press      = r_press;
    assign release_p  = r_release;
    assign long_press = r_long;
    assign repeat_p   = r_repeat;

endmodule
